// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS control FSM with mem_ready handshake, wait timeout and retire counter.
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mc_ctrl_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
                          MEM_WR = 4'd5, EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, HALT = 4'd15;
`ifdef MC_CTRL_ADDI_EN
   localparam logic [3:0] ADDI_EX = 4'd10, ADDI_WB = 4'd11;
`endif
   logic [3:0]    nxt;
   logic [WW-1:0] wcnt;
   logic          waiting, tmo;
   assign waiting = (state == FETCH || state == MEM_RD || state == MEM_WR) && !mem_ready;
   assign tmo     = (TIMEOUT != 0) && waiting && (wcnt == WW'(TIMEOUT - 1));
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= FETCH;
      else state <= nxt;
   always_comb begin
      nxt = HALT;
      case (state)
         FETCH:    nxt = mem_ready ? DECODE : tmo ? HALT : FETCH;
         DECODE:
            case (opcode)
               6'b000000:           nxt = EXEC;
               6'b100011, 6'b101011: nxt = MEM_ADDR;
               6'b000100:           nxt = BRANCH;
               6'b000010:           nxt = JUMP;
`ifdef MC_CTRL_ADDI_EN
               6'b001000:           nxt = ADDI_EX;
`endif
               default:             nxt = HALT;
            endcase
         // lw (100011) and sw (101011) differ only in opcode bit 3
         MEM_ADDR: nxt = opcode[3] ? MEM_WR : MEM_RD;
         MEM_RD:   nxt = mem_ready ? MEM_WB : tmo ? HALT : MEM_RD;
         MEM_WR:   nxt = mem_ready ? FETCH : tmo ? HALT : MEM_WR;
         MEM_WB, R_WB, BRANCH, JUMP: nxt = FETCH;
         EXEC:     nxt = R_WB;
`ifdef MC_CTRL_ADDI_EN
         ADDI_EX:  nxt = ADDI_WB;
         ADDI_WB:  nxt = FETCH;
`endif
         default:  nxt = HALT;
      endcase
   end
   always_comb begin
      {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a} = '0;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      pc_source = 2'b00;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            alu_src_b = 2'b01;
         end
         DECODE:   alu_src_b = 2'b11;
         MEM_ADDR: {alu_src_a, alu_src_b} = 3'b110;
         MEM_RD:   {mem_read, i_or_d} = 2'b11;
         MEM_WB:   {reg_write, mem_to_reg} = 2'b11;
         MEM_WR:   {mem_write, i_or_d} = 2'b11;
         EXEC:     {alu_src_a, alu_op} = 3'b110;
         R_WB:     {reg_write, reg_dst} = 2'b11;
         BRANCH:   {alu_src_a, alu_op, pc_write_cond, pc_source} = 6'b101101;
         JUMP:     {pc_write, pc_source} = 3'b110;
`ifdef MC_CTRL_ADDI_EN
         ADDI_EX:  {alu_src_a, alu_src_b} = 3'b110;
         ADDI_WB:  reg_write = 1'b1;
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fault   <= 1'b0;
         retired <= '0;
         wcnt    <= '0;
      end else begin
         fault   <= fault | (nxt == HALT);
         retired <= retired + CNT_W'(nxt == FETCH && state != FETCH);
         wcnt    <= (nxt != state) ? '0 : waiting ? wcnt + 1'b1 : wcnt;
      end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed scoreboard bench for mc_ctrl_unit (TIMEOUT=4, CNT_W=4).
module tb_mc_ctrl_unit;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         JMP = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;
  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        f;
    logic [3:0]  ret;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state, retired;
  logic fault;
  logic [15:0] ctl_bus;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [3:0] er;
  always #5 clk = ~clk;
  mc_ctrl_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .fault(fault), .retired(retired)
  );
  assign ctl_bus = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic r);
    case (s)
      4'd0:    return {r, 2'b00, 1'b1, 1'b0, r, 4'b0000, 2'b01, 2'b00, 2'b00};
      4'd1:    return {10'b0000000000, 2'b11, 2'b00, 2'b00};
      4'd2:    return {10'b0000000001, 2'b10, 2'b00, 2'b00};
      4'd3:    return {10'b0011000000, 2'b00, 2'b00, 2'b00};
      4'd4:    return {10'b0000001010, 2'b00, 2'b00, 2'b00};
      4'd5:    return {10'b0010100000, 2'b00, 2'b00, 2'b00};
      4'd6:    return {10'b0000000001, 2'b00, 2'b10, 2'b00};
      4'd7:    return {10'b0000000110, 2'b00, 2'b00, 2'b00};
      4'd8:    return {10'b0100000001, 2'b00, 2'b01, 2'b01};
      4'd9:    return {10'b1000000000, 2'b00, 2'b00, 2'b10};
      4'd10:   return {10'b0000000001, 2'b10, 2'b00, 2'b00};
      4'd11:   return {10'b0000000010, 2'b00, 2'b00, 2'b00};
      default: return 16'h0000;
    endcase
  endfunction
  task automatic chk(input logic ok, input string what);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: state=%0d ctl=%b fault=%b retired=%0d", what, state, ctl_bus, fault, retired);
    end
  endtask
  task automatic st(input logic [5:0] op, input logic r, input logic [3:0] s, input logic f, input logic [3:0] ret);
    opcode = op;
    mem_ready = r;
    q.push_back('{st: s, ctl: exp_ctl(s, r), f: f, ret: ret});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;
    #1;
    chk(state == 4'd0 && fault == 1'b0 && retired == 4'd0 && mem_read == 1'b1 && alu_src_b == 2'b01, "reset state");
    q.push_back('{st: 4'd0, ctl: exp_ctl(4'd0, 1'b0), f: 1'b0, ret: 4'd0});
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({state, ctl_bus, fault, retired} !== {e.st, e.ctl, e.f, e.ret}) begin
        n_bad++;
        $display("FAIL cycle%0d: state=%0d ctl=%b fault=%b retired=%0d, expected state=%0d ctl=%b fault=%b retired=%0d",
                 n_cmp, state, ctl_bus, fault, retired, e.st, e.ctl, e.f, e.ret);
      end
    end
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    st(LW, 1, 0, 0, 0); st(LW, 1, 1, 0, 0); st(LW, 1, 2, 0, 0); st(LW, 1, 3, 0, 0); st(LW, 1, 4, 0, 0);
    st(SW, 1, 0, 0, 1); st(SW, 1, 1, 0, 1); st(SW, 1, 2, 0, 1);
    st(SW, 0, 5, 0, 1); st(SW, 0, 5, 0, 1); st(SW, 0, 5, 0, 1); st(SW, 1, 5, 0, 1);
    st(LW, 0, 0, 0, 2); st(LW, 0, 0, 0, 2); st(LW, 0, 0, 0, 2); st(LW, 1, 0, 0, 2);
    st(LW, 1, 1, 0, 2); st(LW, 1, 2, 0, 2);
    st(LW, 0, 3, 0, 2); st(LW, 0, 3, 0, 2); st(LW, 0, 3, 0, 2); st(LW, 1, 3, 0, 2); st(LW, 1, 4, 0, 2);
    st(RT, 1, 0, 0, 3); st(RT, 1, 1, 0, 3); st(RT, 1, 6, 0, 3); st(RT, 1, 7, 0, 3);
    st(BEQ, 1, 0, 0, 4); st(BEQ, 1, 1, 0, 4); st(BEQ, 1, 8, 0, 4);
    st(JMP, 1, 0, 0, 5); st(JMP, 1, 1, 0, 5); st(JMP, 1, 9, 0, 5);
    er = 4'd6;
    for (int i = 0; i < 10; i++) begin
      st(JMP, 1, 0, 0, er); st(JMP, 1, 1, 0, er); st(JMP, 1, 9, 0, er);
      er = er + 4'd1;
    end
`ifdef MC_CTRL_ADDI_EN
    st(ADDI, 1, 0, 0, er); st(ADDI, 1, 1, 0, er); st(ADDI, 1, 10, 0, er); st(ADDI, 1, 11, 0, er);
    st(ADDI, 0, 0, 0, er + 4'd1);
`else
    st(ADDI, 1, 0, 0, er); st(ADDI, 1, 1, 0, er); st(ADDI, 1, 15, 1, er); st(ADDI, 1, 15, 1, er);
`endif
    do_reset();
    st(ILL, 1, 0, 0, 0); st(ILL, 1, 1, 0, 0); st(ILL, 1, 15, 1, 0); st(ILL, 0, 15, 1, 0); st(ILL, 1, 15, 1, 0);
    do_reset();
    st(LW, 0, 0, 0, 0); st(LW, 0, 0, 0, 0); st(LW, 0, 0, 0, 0); st(LW, 0, 0, 0, 0);
    chk(state == 4'd15 && fault == 1'b1 && pc_write == 1'b0, "expired wait");
    st(LW, 0, 15, 1, 0); st(LW, 1, 15, 1, 0);
    do_reset();
    st(LW, 1, 0, 0, 0); st(LW, 1, 1, 0, 0); st(LW, 1, 2, 0, 0); st(LW, 0, 3, 0, 0);
    do_reset();
    st(LW, 1, 0, 0, 0); st(LW, 1, 1, 0, 0); st(LW, 1, 2, 0, 0); st(LW, 1, 3, 0, 0); st(LW, 1, 4, 0, 0);
    st(LW, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multi-cycle MIPS control unit: a Moore state machine that replaces the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back over several cycles so one ALU and one unified memory port are shared. It handles variable-latency memory through a `mem_ready` handshake, with a programmable timeout, and counts retired instructions. It sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

## Interface
- `TIMEOUT`, default 16: maximum wait cycles per memory access before fault; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: asynchronous, active-low reset.
- `opcode` input, 6: `instr[31:26]` from the instruction register.
- `mem_ready` input, 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a` output, 1 each: datapath controls.
- `alu_src_b` output, 2: 00 = B, 01 = 4, 10 = sign-extend, 11 = sign-extend shifted left 2.
- `alu_op` output, 2: 00 = add, 01 = subtract, 10 = funct-decoded.
- `pc_source` output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` output, 4: current state, for debug.
- `fault` output, 1: sticky; set on illegal opcode or timeout.
- `retired` output, `CNT_W`: retired-instruction count.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 15.
- FETCH:
  - Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready` (the only combinational outputs).
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - Opcode routing: 000000 → EXEC; 100011 or 101011 → MEM_ADDR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX (see Configuration).
  - Any other opcode → HALT with `fault` set.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- HALT: all enables are 0. Only reset leaves HALT.
- Unlisted outputs are 0 in every state.
- Timeout:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments on each cycle spent there with `mem_ready`=0.
  - With `TIMEOUT`≠0, the counter reaching `TIMEOUT` → HALT, `fault`=1.
  - The counter is ⌈log2(`TIMEOUT`+1)⌉ bits wide.
- Retirement counter:
  - `retired` increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^`CNT_W`.

## Timing
- Reset values (`rst`=0, asynchronous): `state`=FETCH, `fault`=0, `retired`=0, wait counter 0.
  - Outputs immediately take FETCH values: `mem_read`=1, `alu_src_b`=01, all other outputs 0.
- Reset asserted mid-instruction aborts the instruction without retiring it.
- Latency with `mem_ready` tied to 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each memory wait cycle adds 1.
- `mem_ready` is sampled only while `mem_read` or `mem_write` is asserted; it is ignored in every other state.
- Same-cycle `mem_ready`=1 and timeout: `mem_ready` wins, so there is no fault.

## Configuration
- `MC_CTRL_ADDI_EN` defined: ADDI_EX and ADDI_WB exist, and opcode 001000 is legal.
- Not defined: those states are removed and opcode 001000 is treated as illegal (HALT, `fault`=1).

## Test plan
- Reset, then lw (100011) with `mem_ready`=1 → state sequence 0,1,2,3,4,0; `reg_write`=1 only in state 4; `retired`=1.
- sw with `mem_ready` low for 3 cycles in MEM_WR → `mem_write` held 4 cycles; `retired` increments once; `fault`=0.
- `TIMEOUT`=4 with `mem_ready` stuck 0 in FETCH → HALT after 4 wait cycles; `fault`=1; `pc_write` is never asserted.
- Opcode 111111 → DECODE then HALT, `fault`=1; `rst` pulse low → FETCH, `fault`=0, `retired`=0.
- beq then j → states 0,1,8,0,1,9,0; `pc_write_cond`=1 in 8; `pc_source`=10 in 9; `retired`=2.
- Opcode 001000 → states 0,1,10,11,0 with the macro defined; HALT with `fault`=1 without it.
